// File: rtl/mips_cpu_muldiv.sv
// Iterative HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes.
// Operates on magnitudes and applies sign fixup in a single FINISH cycle.
module mips_cpu_muldiv #(
   parameter int WIDTH           = 32,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int ITER  = WIDTH / STEPS_PER_CYCLE;
   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic             is_mul_op;
   logic             is_div_op;
   logic             is_mthi;
   logic             is_mtlo;
   logic             signed_op;
   logic             accept;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   logic [CNT_W-1:0] cnt;
   logic             is_div;
   logic             div_zero;
   logic             neg_lo;
   logic             neg_hi;
   logic [WIDTH-1:0] hi_acc;
   logic [WIDTH-1:0] lo_acc;
   logic [WIDTH-1:0] opnd;

   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic [WIDTH:0]     trial;
   logic [WIDTH:0]     sum;
   logic               qbit;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   always_comb begin
      is_mul_op = (op[2:1] == 2'b00);
      is_div_op = (op[2:1] == 2'b01);
      is_mthi   = (op == 3'b100);
      is_mtlo   = (op == 3'b101);
      signed_op = ~op[0];
      accept    = start && (state == IDLE) && (is_mul_op || is_div_op);
      a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
      b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST) begin
               state_next = FINISH;
            end
         end
         FINISH: begin
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Multiply: {hi_acc,lo_acc} shifts right, multiplier bits leave lo_acc[0].
   // Divide: dividend bits leave lo_acc MSB into the remainder, quotient enters lo_acc LSB.
   always_comb begin
      step_hi = hi_acc;
      step_lo = lo_acc;
      trial   = '0;
      sum     = '0;
      qbit    = 1'b0;
      for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
         if (is_div) begin
            trial = {step_hi, step_lo[WIDTH-1]};
            qbit  = (trial >= {1'b0, opnd});
            if (qbit) begin
               trial = trial - {1'b0, opnd};
            end
            step_hi = trial[WIDTH-1:0];
            step_lo = {step_lo[WIDTH-2:0], qbit};
         end else begin
            sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], step_lo[WIDTH-1:1]};
         end
      end
   end

   // Divide by zero leaves remainder=|a|, so the normal sign fixup already yields hi=a.
   always_comb begin
      prod     = {hi_acc, lo_acc};
      prod_fix = neg_lo ? -prod : prod;
      if (is_div) begin
         res_hi = neg_hi ? -hi_acc : hi_acc;
         res_lo = div_zero ? {WIDTH{1'b1}} : (neg_lo ? -lo_acc : lo_acc);
      end else begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         cnt      <= '0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         hi_acc   <= '0;
         lo_acc   <= '0;
         opnd     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && is_mthi) begin
                  hi <= a;
               end
               if (start && is_mtlo) begin
                  lo <= a;
               end
               if (accept) begin
                  cnt      <= '0;
                  is_div   <= is_div_op;
                  div_zero <= is_div_op && (b == '0);
                  neg_lo   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_hi   <= signed_op && a[WIDTH-1];
                  hi_acc   <= '0;
                  lo_acc   <= is_div_op ? a_mag : b_mag;
                  opnd     <= is_div_op ? b_mag : a_mag;
               end
            end
            RUN: begin
               hi_acc <= step_hi;
               lo_acc <= step_lo;
               cnt    <= cnt + CNT_W'(1);
            end
            FINISH: begin
               hi   <= res_hi;
               lo   <= res_lo;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: latency, results, sign/zero corner cases,
// MTHI/MTLO handling, mid-run reset, and a radix-4 instance.
module tb_mips_cpu_muldiv;

   localparam int W = 32;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         start4;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy, done, busy4, done4;
   logic [W-1:0] hi, lo, hi4, lo4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mips_cpu_muldiv #(.WIDTH(W), .STEPS_PER_CYCLE(1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   mips_cpu_muldiv #(.WIDTH(W), .STEPS_PER_CYCLE(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b),
      .busy(busy4), .done(done4), .hi(hi4), .lo(lo4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one start pulse from the current negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit to4);
      op = o;
      a  = x;
      b  = y;
      if (to4) start4 = 1'b1;
      else     start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start4 = 1'b0;
      a      = $urandom();
      b      = $urandom();
      op     = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_done(input bit use4, input int max, output int edges, output bit busy_ok);
      edges   = 0;
      busy_ok = 1'b1;
      while (!(use4 ? done4 : done) && edges < max) begin
         if (!(use4 ? busy4 : busy)) busy_ok = 1'b0;
         @(negedge clk);
         edges++;
      end
   endtask

   // Ends on the negedge where done is high, so a follow-up issue lands in the done cycle.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit to4, input int lat,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
      int  edges;
      bit  busy_ok;
      issue(o, x, y, to4);
      wait_done(to4, 100, edges, busy_ok);
      check({tag, "_latency"}, 64'(edges), 64'(lat));
      check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
      check({tag, "_busy_at_done"}, 64'(to4 ? busy4 : busy), 64'd0);
      check({tag, "_hi"}, 64'(to4 ? hi4 : hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(to4 ? lo4 : lo), 64'(exp_lo));
   endtask

   task automatic gap(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  edges;
      bit  busy_ok;
      bit  saw;
      reset  = 1'b0;
      start  = 1'b0;
      start4 = 1'b0;
      op     = 3'b000;
      a      = '0;
      b      = '0;
      repeat (3) @(negedge clk);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33,
             32'hFFFF_FFFE, 32'h0000_0001);
      gap("multu_max");

      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 33,
             32'hFFFF_FFFF, 32'hFFFF_FFF1);
      gap("mult_neg");
      run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 33,
             32'h4000_0000, 32'h0000_0000);
      gap("mult_min");

      run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 33,
             32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_b2b", OP_DIVU, 32'h0000_0007, 32'h0000_0002, 1'b0, 33,
             32'h0000_0001, 32'h0000_0003);
      gap("divu_b2b");

      run_op("div_zero", OP_DIV, 32'h1234_5678, 32'h0000_0000, 1'b0, 33,
             32'h1234_5678, 32'hFFFF_FFFF);
      gap("div_zero");
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33,
             32'h0000_0000, 32'h8000_0000);
      gap("div_ovf");

      issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b0);
      check("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
      check("mthi_lo_kept", 64'(lo), 64'h8000_0000);
      check("mthi_busy", 64'(busy), 64'd0);
      check("mthi_done", 64'(done), 64'd0);

      issue(3'b110, 32'h1111_1111, 32'h2222_2222, 1'b0);
      check("rsv_busy", 64'(busy), 64'd0);
      check("rsv_hi", 64'(hi), 64'hDEAD_BEEF);
      check("rsv_lo", 64'(lo), 64'h8000_0000);

      issue(OP_MTLO, 32'h0000_0055, 32'h0, 1'b0);
      check("mtlo_lo", 64'(lo), 64'h0000_0055);
      check("mtlo_busy", 64'(busy), 64'd0);

      issue(OP_MULT, 32'h0000_0003, 32'h0000_0004, 1'b0);
      repeat (3) @(negedge clk);
      issue(OP_MTLO, 32'hAAAA_AAAA, 32'h0, 1'b0);
      check("mtlo_busy_lo_held", 64'(lo), 64'h0000_0055);
      wait_done(1'b0, 100, edges, busy_ok);
      check("mult_mtlo_latency", 64'(edges + 4), 64'd33);
      check("mult_mtlo_hi", 64'(hi), 64'h0000_0000);
      check("mult_mtlo_lo", 64'(lo), 64'h0000_000C);
      gap("mult_mtlo");

      issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      check("abort_busy_before", 64'(busy), 64'd1);
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      reset = 1'b1;
      saw   = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) saw = 1'b1;
      end
      check("abort_no_done", 64'(saw), 64'd0);
      check("abort_idle_busy", 64'(busy), 64'd0);

      run_op("r4_divu", OP_DIVU, 32'd100, 32'd7, 1'b1, 9, 32'h0000_0002, 32'h0000_000E);
      @(negedge clk);
      check("r4_done_pulse", 64'(done4), 64'd0);
      run_op("r4_mult", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 9,
             32'hFFFF_FFFF, 32'hFFFF_FFF1);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
